regfile_arbiter: RTL and testbench

//  Shares one 32x32 register file among NUM_MASTERS bus requesters.

---
 rtl/regfile_arbiter_if.sv | 24 ++
 rtl/regfile_arbiter.sv | 120 ++++++++++++
 tb/tb_regfile_arbiter.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_arbiter_if.sv
// Master-side bus of the register-file arbiter: per-master request fields
// packed by master index, plus the shared response returned to the grantee.
interface regfile_arbiter_if #(
  parameter int NUM_MASTERS = 4
);
  logic [NUM_MASTERS-1:0]       req;
  logic [NUM_MASTERS-1:0]       req_write;
  logic [NUM_MASTERS-1:0][31:0] req_addr;
  logic [NUM_MASTERS-1:0][31:0] req_wdata;
  logic [NUM_MASTERS-1:0]       ack;
  logic [31:0]                  rdata;
  logic                         err;
  logic                         busy;

  modport master (
    output req, req_write, req_addr, req_wdata,
    input  ack, rdata, err, busy
  );

  modport slave (
    input  req, req_write, req_addr, req_wdata,
    output ack, rdata, err, busy
  );
endinterface

// File: rtl/regfile_arbiter.sv
// Round-robin arbiter sharing one register file among NUM_MASTERS requesters.
// Each transaction walks IDLE -> ISSUE -> (READ_WAIT) -> RESP, or IDLE -> RESP on a bad address.
module regfile_arbiter #(
  parameter int NUM_MASTERS = 4,
  parameter int RF_DEPTH    = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  regfile_arbiter_if.slave bus,
  output logic [31:0] rf_address_o,
  output logic [31:0] rf_data_write_o,
  output logic        rf_write_o,
  output logic        rf_exec_o,
  input  logic [31:0] rf_data_read_i
);

  localparam int IDXW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam logic [IDXW:0] NM = (IDXW+1)'(NUM_MASTERS);

  typedef enum logic [1:0] {IDLE, ISSUE, READ_WAIT, RESP} state_e;

  state_e            state_q, state_d;
  logic [IDXW-1:0]   lastGrant_q, lastGrant_d;
  logic [IDXW-1:0]   grant_q, grant_d;
  logic              write_q, write_d;
  logic              err_q, err_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [31:0]       rfAddr_q, rfAddr_d;
  logic [31:0]       rfWdata_q, rfWdata_d;

  logic              found;
  logic [IDXW-1:0]   pick;
  logic [IDXW:0]     cand;
  logic              addrErr;

  // Search from the master after the last grantee, wrapping modulo NUM_MASTERS.
  always_comb begin
    found = 1'b0;
    pick  = lastGrant_q;
    cand  = '0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      cand = {1'b0, lastGrant_q} + (IDXW+1)'(k);
      if (cand >= NM) cand = cand - NM;
      if (!found && bus.req[cand[IDXW-1:0]]) begin
        found = 1'b1;
        pick  = cand[IDXW-1:0];
      end
    end
  end

  assign addrErr = (bus.req_addr[pick] >= 32'(RF_DEPTH));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (found) state_d = addrErr ? RESP : ISSUE;
      ISSUE:     state_d = write_q ? RESP : READ_WAIT;
      READ_WAIT: state_d = RESP;
      RESP:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Bad addresses never reach the RF pins, so those keep their previous value.
  always_comb begin
    lastGrant_d = lastGrant_q;
    grant_d     = grant_q;
    write_d     = write_q;
    err_d       = err_q;
    rdata_d     = rdata_q;
    rfAddr_d    = rfAddr_q;
    rfWdata_d   = rfWdata_q;
    if (state_q == IDLE && found) begin
      grant_d     = pick;
      lastGrant_d = pick;
      write_d     = bus.req_write[pick];
      err_d       = addrErr;
      if (!addrErr) begin
        rfAddr_d  = bus.req_addr[pick];
        rfWdata_d = bus.req_wdata[pick];
      end
    end
    if (state_q == READ_WAIT) rdata_d = rf_data_read_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      lastGrant_q <= IDXW'(NUM_MASTERS - 1);
      grant_q     <= '0;
      write_q     <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
      rfAddr_q    <= '0;
      rfWdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      lastGrant_q <= lastGrant_d;
      grant_q     <= grant_d;
      write_q     <= write_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
      rfAddr_q    <= rfAddr_d;
      rfWdata_q   <= rfWdata_d;
    end
  end

  always_comb begin
    bus.ack = '0;
    if (state_q == RESP) bus.ack[grant_q] = 1'b1;
    bus.err         = (state_q == RESP) && err_q;
    bus.rdata       = rdata_q;
    bus.busy        = (state_q != IDLE);
    rf_exec_o       = (state_q == ISSUE);
    rf_write_o      = (state_q == ISSUE) && write_q;
    rf_address_o    = rfAddr_q;
    rf_data_write_o = rfWdata_q;
  end

endmodule

// File: tb/tb_regfile_arbiter.sv
// Directed bench for regfile_arbiter: a table of single transactions plus
// hand-written sequences for round-robin, contention, reset and held fields.
module tb_regfile_arbiter;

  logic        clk;
  logic        rst_n;
  logic [31:0] rf_address;
  logic [31:0] rf_data_write;
  logic        rf_write;
  logic        rf_exec;
  logic [31:0] rf_data_read;
  logic [31:0] mem [0:31];

  int total = 0;
  int bad   = 0;

  regfile_arbiter_if #(.NUM_MASTERS(4)) bus ();

  regfile_arbiter #(.NUM_MASTERS(4), .RF_DEPTH(32)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .bus             (bus),
    .rf_address_o    (rf_address),
    .rf_data_write_o (rf_data_write),
    .rf_write_o      (rf_write),
    .rf_exec_o       (rf_exec),
    .rf_data_read_i  (rf_data_read)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model with one cycle of read latency.
  always @(posedge clk) begin
    if (rf_exec) begin
      if (rf_write) mem[rf_address[4:0]] <= rf_data_write;
      rf_data_read <= mem[rf_address[4:0]];
    end
  end

  typedef struct {
    int          master;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  vec_t vecs[10];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input int m, input logic wr, input logic [31:0] addr,
                               input logic [31:0] wdata, input int expLat,
                               input logic [31:0] expRdata, input logic expErr,
                               input string tag);
    int lat = 0;
    int execCnt = 0;
    logic gotAck = 1'b0;
    logic [3:0] ackSeen = '0;
    logic errSeen = 1'b0;
    logic [31:0] rdSeen = '0;
    @(negedge clk);
    bus.req_write[m] = wr;
    bus.req_addr[m]  = addr;
    bus.req_wdata[m] = wdata;
    bus.req[m]       = 1'b1;
    for (int c = 1; c <= 12 && !gotAck; c++) begin
      @(negedge clk);
      if (rf_exec) begin
        execCnt++;
        checkOutput({tag, " rf_address"}, rf_address, addr);
        checkOutput({tag, " rf_write"}, 32'(rf_write), 32'(wr));
        if (wr) checkOutput({tag, " rf_data_write"}, rf_data_write, wdata);
      end
      if (bus.ack != 4'b0) begin
        gotAck  = 1'b1;
        lat     = c;
        ackSeen = bus.ack;
        errSeen = bus.err;
        rdSeen  = bus.rdata;
        bus.req[m] = 1'b0;
      end
    end
    bus.req[m] = 1'b0;
    checkOutput({tag, " latency"}, 32'(lat), 32'(expLat));
    checkOutput({tag, " ack"}, 32'(ackSeen), 32'(1 << m));
    checkOutput({tag, " err"}, 32'(errSeen), 32'(expErr));
    checkOutput({tag, " rdata"}, rdSeen, expRdata);
    checkOutput({tag, " exec count"}, 32'(execCnt), expErr ? 32'd0 : 32'd1);
  endtask

  task automatic waitIdle(input string tag);
    int c = 0;
    while (bus.busy && c < 20) begin
      @(negedge clk);
      c++;
    end
    checkOutput({tag, " idle"}, 32'(bus.busy), 32'd0);
  endtask

  task automatic resetDut();
    @(negedge clk);
    rst_n = 1'b0;
    bus.req = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Collect a fixed sequence of acks, failing on timeout.
  task automatic expectAcks(input int expOrder[6], input int count, input string tag);
    int n = 0;
    for (int c = 0; c < 60 && n < count; c++) begin
      @(negedge clk);
      if (bus.ack != 4'b0) begin
        checkOutput($sformatf("%s ack %0d", tag, n), 32'(bus.ack), 32'(1 << expOrder[n]));
        n++;
      end
    end
    checkOutput({tag, " ack count"}, 32'(n), 32'(count));
  endtask

  initial begin
    int rrOrder[6]  = '{0, 1, 2, 3, 0, 1};
    int conOrder[6] = '{0, 3, 0, 0, 0, 0};
    logic gotAck;

    for (int i = 0; i < 32; i++) mem[i] = '0;
    rf_data_read  = '0;
    rst_n         = 1'b0;
    bus.req       = '0;
    bus.req_write = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;

    vecs[0] = '{1, 1'b1, 32'd5,          32'hDEADBEEF, 2, 32'h00000000, 1'b0};
    vecs[1] = '{1, 1'b0, 32'd5,          32'h0,        3, 32'hDEADBEEF, 1'b0};
    vecs[2] = '{2, 1'b0, 32'h20,         32'h0,        1, 32'hDEADBEEF, 1'b1};
    vecs[3] = '{0, 1'b1, 32'd31,         32'h12345678, 2, 32'hDEADBEEF, 1'b0};
    vecs[4] = '{3, 1'b0, 32'd31,         32'h0,        3, 32'h12345678, 1'b0};
    vecs[5] = '{0, 1'b1, 32'd0,          32'hA5A5A5A5, 2, 32'h12345678, 1'b0};
    vecs[6] = '{2, 1'b0, 32'd0,          32'h0,        3, 32'hA5A5A5A5, 1'b0};
    vecs[7] = '{3, 1'b1, 32'hFFFFFFFF,   32'h11111111, 1, 32'hA5A5A5A5, 1'b1};
    vecs[8] = '{2, 1'b0, 32'd7,          32'h0,        3, 32'h00000000, 1'b0};
    vecs[9] = '{1, 1'b0, 32'd31,         32'h0,        3, 32'h12345678, 1'b0};

    @(negedge clk);
    @(negedge clk);
    checkOutput("reset ack", 32'(bus.ack), 32'd0);
    checkOutput("reset err", 32'(bus.err), 32'd0);
    checkOutput("reset busy", 32'(bus.busy), 32'd0);
    checkOutput("reset rf_exec", 32'(rf_exec), 32'd0);
    checkOutput("reset rf_write", 32'(rf_write), 32'd0);
    checkOutput("reset rdata", bus.rdata, 32'd0);
    checkOutput("reset rf_address", rf_address, 32'd0);
    checkOutput("reset rf_data_write", rf_data_write, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].master, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
                    vecs[i].lat, vecs[i].rdata, vecs[i].err, $sformatf("vec%0d", i));
      waitIdle($sformatf("vec%0d", i));
    end

    // Reset during READ_WAIT drops the transaction and restarts arbitration at master 0.
    @(negedge clk);
    bus.req_write[2] = 1'b0;
    bus.req_addr[2]  = 32'd5;
    bus.req[2]       = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst mid busy", 32'(bus.busy), 32'd1);
    checkOutput("rst mid rf_exec", 32'(rf_exec), 32'd0);
    rst_n = 1'b0;
    #1;
    checkOutput("rst mid ack", 32'(bus.ack), 32'd0);
    checkOutput("rst mid busy low", 32'(bus.busy), 32'd0);
    checkOutput("rst mid rdata", bus.rdata, 32'd0);
    checkOutput("rst mid rf_address", rf_address, 32'd0);
    checkOutput("rst mid rf_data_write", rf_data_write, 32'd0);
    @(negedge clk);
    checkOutput("rst held ack", 32'(bus.ack), 32'd0);
    checkOutput("rst held rdata", bus.rdata, 32'd0);
    bus.req_write[0] = 1'b0;
    bus.req_addr[0]  = 32'd5;
    bus.req[0]       = 1'b1;
    rst_n = 1'b1;
    gotAck = 1'b0;
    for (int c = 0; c < 20 && !gotAck; c++) begin
      @(negedge clk);
      if (bus.ack != 4'b0) begin
        gotAck = 1'b1;
        checkOutput("rst first ack", 32'(bus.ack), 32'd1);
        checkOutput("rst first rdata", bus.rdata, 32'hDEADBEEF);
        bus.req = '0;
      end
    end
    bus.req = '0;
    checkOutput("rst first ack seen", 32'(gotAck), 32'd1);
    waitIdle("rst");

    // All four masters request continuously.
    resetDut();
    for (int i = 0; i < 4; i++) begin
      bus.req_write[i] = 1'b0;
      bus.req_addr[i]  = 32'(i);
    end
    bus.req = 4'hF;
    expectAcks(rrOrder, 6, "rr");
    bus.req = '0;
    waitIdle("rr");

    // Master 3 arrives while master 0 is in service and keeps priority over a re-request.
    resetDut();
    bus.req_write[0] = 1'b0;
    bus.req_addr[0]  = 32'd3;
    bus.req[0]       = 1'b1;
    @(negedge clk);
    bus.req_write[3] = 1'b0;
    bus.req_addr[3]  = 32'd4;
    bus.req[3]       = 1'b1;
    expectAcks(conOrder, 3, "contention");
    bus.req = '0;
    waitIdle("contention");

    // Address change after grant must not reach the RF pins.
    @(negedge clk);
    bus.req_write[0] = 1'b1;
    bus.req_addr[0]  = 32'd3;
    bus.req_wdata[0] = 32'hCAFEF00D;
    bus.req[0]       = 1'b1;
    @(negedge clk);
    checkOutput("held issue exec", 32'(rf_exec), 32'd1);
    bus.req_addr[0] = 32'd7;
    #1;
    checkOutput("held rf_address", rf_address, 32'd3);
    gotAck = 1'b0;
    for (int c = 0; c < 10 && !gotAck; c++) begin
      @(negedge clk);
      if (bus.ack != 4'b0) begin
        gotAck = 1'b1;
        bus.req = '0;
      end
    end
    bus.req = '0;
    checkOutput("held ack seen", 32'(gotAck), 32'd1);
    waitIdle("held");
    applyStimulus(0, 1'b0, 32'd3, 32'h0, 3, 32'hCAFEF00D, 1'b0, "held rd3");
    waitIdle("held rd3");
    applyStimulus(0, 1'b0, 32'd7, 32'h0, 3, 32'h00000000, 1'b0, "held rd7");
    waitIdle("held rd7");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
